// File: rtl/ps2_key_event_controller.sv
// Turns PS/2 scan-code bytes into make/break key events.
// Also maintains the sticky sharp/octave toggles and the active note key.
module ps2_key_event_controller #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       sharp_mode,
  output logic       octave_mode,
  output logic       note_on,
  output logic [7:0] note_key,
  output logic       event_strobe,
  output logic       event_break,
  output logic       event_ext,
  output logic [7:0] event_code
);

  localparam logic [7:0]       CODE_BRK    = 8'hF0;
  localparam logic [7:0]       CODE_EXT    = 8'hE0;
  localparam logic [7:0]       CODE_ENTER  = 8'h5A;
  localparam logic [7:0]       CODE_RSHIFT = 8'h59;
  localparam logic [39:0]      IGNORE_CODES = {8'hFF, 8'hFE, 8'hFA, 8'hAA, 8'h00};
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             enter_held_reg, rshift_held_reg;
  logic [4:0]       ign_hit;
  logic             ignored, timeout_hit;
  logic             ev_fire, ev_break, ev_ext;

  // Receiver housekeeping bytes (BAT/ACK/resend/error) never form key events.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_ignore
      assign ign_hit[gi] = (data == IGNORE_CODES[gi*8 +: 8]);
    end
  endgenerate

  assign ignored     = |ign_hit;
  assign timeout_hit = (state_reg != IDLE) && !data_valid && (cnt_reg == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || data_valid || state_reg == IDLE) cnt_reg <= '0;
    else                                           cnt_reg <= cnt_reg + CNT_W'(1);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (data_valid && data == CODE_BRK)      state_next = BRK;
        else if (data_valid && data == CODE_EXT) state_next = EXT;
      end
      BRK:     if (data_valid) state_next = IDLE;
      EXT:     if (data_valid) state_next = (data == CODE_BRK) ? EXT_BRK : IDLE;
      EXT_BRK: if (data_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout_hit) state_next = IDLE;
  end

  always_comb begin
    ev_fire  = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;
    case (state_reg)
      IDLE:    ev_fire = data_valid && data != CODE_BRK && data != CODE_EXT && !ignored;
      BRK:     begin ev_fire = data_valid; ev_break = 1'b1; end
      EXT:     begin ev_fire = data_valid && data != CODE_BRK; ev_ext = 1'b1; end
      EXT_BRK: begin ev_fire = data_valid; ev_break = 1'b1; ev_ext = 1'b1; end
      default: ev_fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      event_strobe    <= 1'b0;
      event_break     <= 1'b0;
      event_ext       <= 1'b0;
      event_code      <= 8'h00;
      sharp_mode      <= 1'b0;
      octave_mode     <= 1'b0;
      enter_held_reg  <= 1'b0;
      rshift_held_reg <= 1'b0;
      note_on         <= 1'b0;
      note_key        <= 8'h00;
    end else begin
      event_strobe <= ev_fire;
      if (ev_fire) begin
        event_break <= ev_break;
        event_ext   <= ev_ext;
        event_code  <= data;
        // Held flags swallow typematic repeats so a held key toggles once.
        if (!ev_ext) begin
          if (data == CODE_ENTER) begin
            if (!ev_break && !enter_held_reg) sharp_mode <= ~sharp_mode;
            enter_held_reg <= !ev_break;
          end else if (data == CODE_RSHIFT) begin
            if (!ev_break && !rshift_held_reg) octave_mode <= ~octave_mode;
            rshift_held_reg <= !ev_break;
          end else if (!ev_break) begin
            note_key <= data;
            note_on  <= 1'b1;
          end else if (note_on && data == note_key) begin
            note_on <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/ps2_key_event_controller.md
Name: ps2_key_event_controller

Overview:
- Sequences decoded PS/2 scan-code bytes into key make/break events for the audio controller.
- Owns the sticky-mode toggles: Enter (0x5A) is sharp notes, Rshift (0x59) is octave.
- Suppresses typematic auto-repeat so a held key does not re-toggle a mode.
- Tracks the single active note key (last-pressed wins) for the tone generator.
- Sits between the PS/2 byte receiver (byte + valid strobe, system clock domain) and the note/tone datapath.

Parameters:
- TIMEOUT_CYCLES, 50000, clk cycles allowed after a prefix byte (0xE0/0xF0) before the sequence is abandoned.
- CNT_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- data  input  8  scan-code byte from PS/2 receiver.
- data_valid  input  1  one-cycle strobe; data sampled only when high.
- sharp_mode  output  1  sticky sharp toggle (Enter).
- octave_mode  output  1  sticky octave toggle (Rshift).
- note_on  output  1  a note key is currently held.
- note_key  output  8  scan code of active note key.
- event_strobe  output  1  one-cycle pulse per completed key event.
- event_break  output  1  valid with event_strobe: 1 = release, 0 = press.
- event_ext  output  1  valid with event_strobe: 1 = E0-prefixed code.
- event_code  output  8  valid with event_strobe: final (non-prefix) byte.

Behaviour:
- Reset: one clock, synchronous, active-low.
  - Reset state: IDLE, timeout counter 0, enter_held = 0, rshift_held = 0.
  - All outputs 0.
  - Reset mid-sequence discards any pending prefix.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: data_valid with 0xF0 goes to BRK; 0xE0 goes to EXT; 0x00, 0xAA, 0xFA, 0xFE, 0xFF are ignored (no event, stay IDLE); any other byte is a make event, stay IDLE.
  - BRK: any byte is a break event; go to IDLE.
  - EXT: 0xF0 goes to EXT_BRK; any other byte is an extended make; go to IDLE.
  - EXT_BRK: any byte is an extended break; go to IDLE.
- Timeout:
  - Counter clears on every data_valid and in IDLE; increments each cycle in BRK/EXT/EXT_BRK.
  - On reaching TIMEOUT_CYCLES-1 without data_valid: go to IDLE, no event.
  - data_valid in the same cycle as expiry: the byte is processed normally and the timeout is ignored.
- Event outputs:
  - Registered; event_strobe is high exactly on the cycle after the data_valid that completes the event.
  - event_break, event_ext and event_code are updated in that same cycle and hold until the next event.
- Mode toggles (non-extended codes only):
  - Make 0x5A with enter_held = 0: invert sharp_mode, set enter_held.
  - Make 0x5A with enter_held = 1 (typematic repeat): no change.
  - Break 0x5A: clear enter_held.
  - 0x59 applies the same rules to octave_mode / rshift_held.
  - Extended codes (e.g. keypad Enter E0 5A) never toggle modes.
  - Mode outputs change in the same cycle as event_strobe.
- Note tracking (non-extended, non-0x5A, non-0x59 codes):
  - Make code C: note_key <= C, note_on <= 1. A repeat of the same C is idempotent; a different C replaces it (last-pressed wins).
  - Break of C == note_key while note_on: note_on <= 0, note_key retained.
  - Break of C != note_key: no change to note outputs; the event is still strobed.
  - Extended codes never affect note outputs.
- Latency: 1 clk from data_valid to every output update. Back-to-back data_valid on consecutive cycles must be accepted.

Test Plan:
- Reset then bytes 5A, 5A, 5A, F0 5A, 5A -> sharp_mode 0→1 after first 5A, stays 1 through the repeats, 1→0 after the final 5A; 4 make events + 1 break strobed.
- Bytes 1C, 1B, F0 1C, F0 1B -> note_key 1C then 1B with note_on 1; note_on stays 1 after F0 1C; note_on 0 after F0 1B, note_key = 1B.
- Bytes E0 5A, E0 F0 5A -> two strobes with event_ext = 1 and event_break 0 then 1; sharp_mode and note outputs unchanged.
- F0 then no byte for TIMEOUT_CYCLES, then 59 -> no strobe from the timeout; the 59 is treated as a make, octave_mode 0→1.
- Bytes 1C then rst_n low 1 cycle mid E0 sequence, then F0 1C -> all outputs 0 after reset; F0 1C strobes a break with note_on staying 0.
- data_valid on 3 consecutive cycles: F0, 59, 59 -> break then make strobes on consecutive cycles; octave_mode toggles once (1 cycle after the third byte).
